// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage; one valid/ready bus transaction per load/store with lane/strobe formatting.
// Ports: clk/reset (async, active-high); request start/is_load/is_store/funct3/address/store_data;
// bus mem_valid/mem_ready/mem_address/mem_wstrobes/mem_wdata/mem_rdata;
// status busy/done/bus_error and formatted load_data.
// Optional LSU_MISALIGN_TRAP_EN adds output misaligned and skips the bus for misaligned halfword/word accesses.
module load_store_unit #(
  parameter int timeout = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_wstrobes,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        bus_error,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [31:0] load_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, next;
  logic ld_q, err_q, mis_q, req, trap, expired;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [31:0] wait_cnt, st_wdata, ld_fmt;
  logic [3:0] st_strb;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    req = start && (is_load || is_store);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = req && (funct3[1:0] == 2'b01 ? address[0] : funct3[1:0] != 2'b00 && address[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    expired = timeout != 0 && !mem_ready && wait_cnt == 32'(timeout - 1);
    next = state == IDLE ? (start ? (req && !trap ? ACCESS : DONE) : IDLE)
         : state == ACCESS ? (mem_ready || expired ? DONE : ACCESS)
         : IDLE;
    st_strb = !is_store ? 4'b0000
            : funct3[1:0] == 2'b00 ? 4'b0001 << address[1:0]
            : funct3[1:0] == 2'b01 ? (address[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
    st_wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}}
             : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}}
             : store_data;
    b = mem_rdata[8*off_q +: 8];
    h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] selects zero extension (LBU/LHU)
    ld_fmt = f3_q[1:0] == 2'b00 ? {{24{b[7] & ~f3_q[2]}}, b}
           : f3_q[1:0] == 2'b01 ? {{16{h[15] & ~f3_q[2]}}, h}
           : mem_rdata;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_address <= '0;
      mem_wstrobes <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      ld_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      wait_cnt <= '0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else if (state == IDLE && start) begin
      err_q <= 1'b0;
      mis_q <= trap;
      wait_cnt <= '0;
      if (req) begin
        mem_address <= {address[31:2], 2'b00};
        mem_wstrobes <= st_strb;
        mem_wdata <= st_wdata;
        ld_q <= is_load && !is_store;
        f3_q <= funct3;
        off_q <= address[1:0];
      end
    end else if (state == ACCESS) begin
      if (mem_ready) load_data <= ld_q ? ld_fmt : load_data;
      else if (expired) err_q <= 1'b1;
      else wait_cnt <= wait_cnt + 32'd1;
    end
  // mem_valid decodes state so an async reset drops it immediately
  assign mem_valid = state == ACCESS;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bus_error = done && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = done && mis_q;
`endif
endmodule
